// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default
// 100 MHz timing constants and a saturating-increment helper.
package rst_seq_pkg;

  // Sequencer states, in the order a clean power-up walks through them.
  typedef enum logic [2:0] {
    WIZ_RST   = 3'd0,  // holding the clock wizard in reset
    WAIT_LOCK = 3'd1,  // wizard released, waiting for locked
    STABLE    = 3'd2,  // locked seen, qualifying that it stays up
    REL_CORE  = 3'd3,  // core reset released, peripherals still held
    RUN       = 3'd4   // everything released
  } seq_state_t;

  // Default timing for a 100 MHz sequencer clock.
  localparam int unsigned DEF_WIZ_RST_CYCLES     = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 100000;  // 1 ms
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 10000;   // 100 us
  localparam int unsigned DEF_STAGE_GAP          = 16;
  localparam int unsigned DEF_CNT_W              = 17;

  // Width of the lock-loss counter exposed on the port.
  localparam int unsigned LOSS_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    logic [LOSS_CNT_W-1:0] r;
    r = v;
    if (v != {LOSS_CNT_W{1'b1}}) begin
      r = v + LOSS_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer for bringing asynchronous level signals
// into the local clock domain. Each bit is synchronized independently, so
// multi-bit use is only valid for unrelated flags, never for a bus value.
// The flops carry no reset on purpose: they only ever hold a copy of the
// input and must keep tracking it while the rest of the logic is in reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_q;
    logic sync_q;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge clk) begin
      meta_q <= d[gi];
      sync_q <= meta_q;
    end

    assign q[gi] = sync_q;
  end

endmodule

// File: rtl/rst_seq.sv
// Power-up / lock-recovery reset sequencer for the clock wizard.
// Pulses the wizard reset, waits for lock, qualifies it for a fixed
// interval, then releases the core reset and, a few cycles later, the
// peripheral reset. Runs from the free-running board clock because the
// wizard outputs stop while it is held in reset.
//
// Optional build macro RST_SEQ_LOSS_CNT_EN: when defined, lock_loss_cnt
// counts (saturating) lock losses seen after the first release; when
// undefined the counter is not built and lock_loss_cnt reads 0.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned WIZ_RST_CYCLES     = DEF_WIZ_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP          = DEF_STAGE_GAP,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic                  clk_100M,
  input  logic                  reset,
  input  logic                  locked,
  output logic                  clk_wiz_reset,
  output logic                  rst_core,
  output logic                  rst_periph,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  // Terminal timer values; each phase starts at 0 and leaves on its last count.
  localparam logic [CNT_W-1:0] WIZ_LAST     = CNT_W'(WIZ_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);

  logic locked_s;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             clk_wiz_reset_q, clk_wiz_reset_d;
  logic             rst_core_q, rst_core_d;
  logic             rst_periph_q, rst_periph_d;
  logic             ready_q, ready_d;

  // locked comes straight from the wizard with no relation to clk_100M.
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (clk_100M),
    .d   (locked),
    .q   (locked_s)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    clk_wiz_reset_d = clk_wiz_reset_q;
    rst_core_d      = rst_core_q;
    rst_periph_d    = rst_periph_q;
    ready_d         = ready_q;

    case (state_q)
      WIZ_RST: begin
        clk_wiz_reset_d = 1'b1;
        rst_core_d      = 1'b1;
        rst_periph_d    = 1'b1;
        ready_d         = 1'b0;
        if (timer_q == WIZ_LAST) begin
          state_d         = WAIT_LOCK;
          timer_d         = '0;
          clk_wiz_reset_d = 1'b0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      WAIT_LOCK: begin
        clk_wiz_reset_d = 1'b0;
        rst_core_d      = 1'b1;
        rst_periph_d    = 1'b1;
        ready_d         = 1'b0;
        if (locked_s) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          // Wizard never locked: pulse its reset again and start over.
          state_d         = WIZ_RST;
          timer_d         = '0;
          clk_wiz_reset_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      STABLE: begin
        if (!locked_s) begin
          // Nothing was released yet, so this is not a counted loss.
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d    = REL_CORE;
          timer_d    = '0;
          rst_core_d = 1'b0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      REL_CORE: begin
        if (!locked_s) begin
          state_d      = WAIT_LOCK;
          timer_d      = '0;
          rst_core_d   = 1'b1;
          rst_periph_d = 1'b1;
          ready_d      = 1'b0;
        end else if (timer_q == GAP_LAST) begin
          state_d      = RUN;
          timer_d      = '0;
          rst_periph_d = 1'b0;
          ready_d      = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      RUN: begin
        // The wizard is not reset here; if it never relocks, the
        // WAIT_LOCK timeout takes care of it.
        if (!locked_s) begin
          state_d      = WAIT_LOCK;
          timer_d      = '0;
          rst_core_d   = 1'b1;
          rst_periph_d = 1'b1;
          ready_d      = 1'b0;
        end
      end

      default: begin
        state_d         = WIZ_RST;
        timer_d         = '0;
        clk_wiz_reset_d = 1'b1;
        rst_core_d      = 1'b1;
        rst_periph_d    = 1'b1;
        ready_d         = 1'b0;
      end
    endcase
  end

  // Sequencer state, timer and registered outputs; reset restarts from WIZ_RST.
  always_ff @(posedge clk_100M) begin
    if (reset) begin
      state_q         <= WIZ_RST;
      timer_q         <= '0;
      clk_wiz_reset_q <= 1'b1;
      rst_core_q      <= 1'b1;
      rst_periph_q    <= 1'b1;
      ready_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      clk_wiz_reset_q <= clk_wiz_reset_d;
      rst_core_q      <= rst_core_d;
      rst_periph_q    <= rst_periph_d;
      ready_q         <= ready_d;
    end
  end

  assign clk_wiz_reset = clk_wiz_reset_q;
  assign rst_core      = rst_core_q;
  assign rst_periph    = rst_periph_q;
  assign ready         = ready_q;

`ifdef RST_SEQ_LOSS_CNT_EN
  logic                  loss_event;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  // A loss only counts once the core has been released.
  assign loss_event = ((state_q == REL_CORE) || (state_q == RUN)) && !locked_s;

  // Saturating lock-loss count.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_event) begin
      loss_cnt_d = sat_inc(loss_cnt_q);
    end
  end

  // Loss counter register, cleared by reset.
  always_ff @(posedge clk_100M) begin
    if (reset) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Testbench for rst_seq: directed scenarios plus randomized lock/reset
// traffic, compared every cycle against a counter-based model of the
// sequencing rules.
`timescale 1ns/1ps
module tb_rst_seq;

  localparam int WIZ_N  = 3;
  localparam int TMO    = 50;
  localparam int STAB   = 10;
  localparam int GAP    = 4;
  // Consecutive synchronized-lock samples after which core / all resets release.
  localparam int REL_AT = STAB + 1;
  localparam int RUN_AT = STAB + 1 + GAP;
`ifdef RST_SEQ_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk_100M = 1'b0;
  logic       reset    = 1'b1;
  logic       locked   = 1'b0;
  logic       clk_wiz_reset, rst_core, rst_periph, ready;
  logic [7:0] lock_loss_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_100M = ~clk_100M;

  rst_seq #(
    .WIZ_RST_CYCLES     (WIZ_N),
    .LOCK_TIMEOUT       (TMO),
    .LOCK_STABLE_CYCLES (STAB),
    .STAGE_GAP          (GAP),
    .CNT_W              (17)
  ) dut (
    .clk_100M      (clk_100M),
    .reset         (reset),
    .locked        (locked),
    .clk_wiz_reset (clk_wiz_reset),
    .rst_core      (rst_core),
    .rst_periph    (rst_periph),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // wiz_left : wizard-reset cycles still to go
  // streak   : consecutive synchronized-lock samples since the lock last broke
  // idle     : consecutive unlocked samples while waiting (timeout)
  // losses   : losses seen while streak had reached the release point
  int m_wiz_left = 0, m_streak = 0, m_idle = 0, m_losses = 0;
  bit m_valid = 1'b0;
  bit m_hist0 = 1'b0, m_hist1 = 1'b0;

  task automatic model_step();
    bit ls;
    ls      = m_hist1;   // locked as sampled two edges ago
    m_hist1 = m_hist0;
    m_hist0 = locked;
    if (reset) begin
      m_wiz_left = WIZ_N;
      m_streak   = 0;
      m_idle     = 0;
      m_losses   = 0;
      m_valid    = 1'b1;
    end else if (m_valid) begin
      if (m_wiz_left > 0) begin
        m_wiz_left--;
      end else if (ls) begin
        m_idle = 0;
        if (m_streak < RUN_AT) m_streak++;
      end else if (m_streak > 0) begin
        if (m_streak >= REL_AT) m_losses++;
        m_streak = 0;
        m_idle   = 0;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_wiz_left = WIZ_N;
          m_idle     = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk_100M);
    model_step();
  end

  // Compare DUT outputs against the model on every falling edge.
  initial forever begin
    @(negedge clk_100M);
    if (m_valid) begin
      check("clk_wiz_reset", clk_wiz_reset, (m_wiz_left > 0) ? 1 : 0);
      check("rst_core",      rst_core,      (m_streak < REL_AT) ? 1 : 0);
      check("rst_periph",    rst_periph,    (m_streak < RUN_AT) ? 1 : 0);
      check("ready",         ready,         (m_streak >= RUN_AT) ? 1 : 0);
      check("lock_loss_cnt", lock_loss_cnt, CNT_EN ? ((m_losses > 255) ? 255 : m_losses) : 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_100M);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int lo;
    reset  = 1'b1;
    locked = 1'b0;
    cycles(4);

    // Test 1: clean power-up.
    reset = 1'b0;
    k = 0;
    while (clk_wiz_reset === 1'b1 && k < 20) begin k++; @(negedge clk_100M); end
    check("t1_wiz_pulse_len", k, WIZ_N);
    cycles(4);
    locked = 1'b1;
    k = 0;
    // 2 sync stages + 1 detect cycle + STAB qualifying cycles
    while (rst_core === 1'b1 && k < 200) begin @(negedge clk_100M); k++; end
    check("t1_lock_to_core", k, 13);
    k = 0;
    while (rst_periph === 1'b1 && k < 50) begin @(negedge clk_100M); k++; end
    check("t1_core_to_periph", k, GAP);
    check("t1_ready", ready, 1);
    check("t1_loss_cnt", lock_loss_cnt, 0);
    $display("[TB] test1 power-up: lock_to_core done, periph gap checked");

    // Test 4: lock loss in RUN for 20 cycles.
    cycles(5);
    locked = 1'b0;
    k = 0;
    while (rst_core === 1'b0 && k < 50) begin @(negedge clk_100M); k++; end
    check("t4_loss_latency", k, 3);
    check("t4_periph", rst_periph, 1);
    check("t4_ready", ready, 0);
    check("t4_loss_cnt", lock_loss_cnt, CNT_EN ? 1 : 0);
    cycles(17);
    locked = 1'b1;
    k = 0;
    while (rst_periph === 1'b1 && k < 200) begin @(negedge clk_100M); k++; end
    check("t4_rerelease", k, 2 + 1 + STAB + GAP);
    $display("[TB] test4 lock loss in RUN and re-release");

    // Test 3: one-cycle glitch at STABLE timer=6 restarts qualification.
    cycles(5);
    locked = 1'b0;        // second counted loss
    cycles(10);
    locked = 1'b1;
    cycles(7);
    locked = 1'b0;
    cycles(1);
    locked = 1'b1;
    k = 8;
    while (rst_core === 1'b1 && k < 200) begin @(negedge clk_100M); k++; end
    check("t3_glitch_release", k, 21);
    check("t3_loss_cnt", lock_loss_cnt, CNT_EN ? 2 : 0);
    $display("[TB] test3 STABLE glitch restarts qualification");

    // Test 2: locked never rises -> periodic wizard retries.
    locked = 1'b0;
    reset  = 1'b1;
    cycles(2);
    reset = 1'b0;
    k = 0;
    while (clk_wiz_reset === 1'b1 && k < 20) begin @(negedge clk_100M); k++; end
    for (int p = 0; p < 2; p++) begin
      lo = 0;
      while (clk_wiz_reset === 1'b0 && lo < 200) begin @(negedge clk_100M); lo++; end
      check("t2_low_len", lo, TMO);
      k = 0;
      while (clk_wiz_reset === 1'b1 && k < 20) begin @(negedge clk_100M); k++; end
      check("t2_pulse_len", k, WIZ_N);
      $display("[TB] test2 retry %0d: low=%0d high=%0d", p, lo, k);
    end

    // Test 5: 300 losses saturate the counter.
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      cycles(18);
      locked = 1'b0;
      cycles(4);
    end
    check("t5_saturated", lock_loss_cnt, CNT_EN ? 255 : 0);
    $display("[TB] test5 300 lock losses, count=%0d", lock_loss_cnt);

    // Test 6: reset while in RUN.
    locked = 1'b1;
    cycles(20);
    check("t6_in_run", ready, 1);
    reset = 1'b1;
    cycles(1);
    check("t6_wiz", clk_wiz_reset, 1);
    check("t6_core", rst_core, 1);
    check("t6_periph", rst_periph, 1);
    check("t6_ready", ready, 0);
    check("t6_cnt", lock_loss_cnt, 0);
    reset = 1'b0;
    $display("[TB] test6 reset in RUN");

    // Randomized lock/reset traffic.
    for (int s = 0; s < 60; s++) begin
      int r;
      int d;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        reset = 1'b1;
        cycles(int'($urandom_range(1, 3)));
        reset = 1'b0;
      end else if (r > 4) begin
        locked = 1'b1;
        d = int'($urandom_range(1, 40));
        cycles(d);
      end else begin
        locked = 1'b0;
        d = int'($urandom_range(1, 70));
        cycles(d);
      end
      $display("[TB] random segment %0d: kind=%0d locked=%0b reset=%0b", s, r, locked, reset);
    end
    cycles(5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
